keynsham_ram_arbiter: RTL and testbench

- Two-master arbiter for the data port of the on-chip RAM.
- Master 0 is the CPU data bus; master 1 is the debug/DMA bus.
- Grants the shared data port round-robin and sequences one access at a time.
- Returns the read data and ack to the granted master, and times out a missing RAM ack so a master can never hang.

---
 rtl/keynsham_ram_arb_pkg.sv | 17 +
 rtl/keynsham_ram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_keynsham_ram_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keynsham_ram_arb_pkg.sv
// Shared types and constants for the two-master RAM data-port arbiter.
package keynsham_ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Master indices: CPU data bus and debug/DMA bus.
  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

  // Read data returned to a master whose access timed out.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADDEAD;

endpackage

// File: rtl/keynsham_ram_arbiter.sv
// Round-robin arbiter sharing the on-chip RAM data port between the CPU
// (master 0) and the debug/DMA bus (master 1). One access in flight at a
// time; a missing RAM ack is converted into an error ack after TIMEOUT cycles.
module keynsham_ram_arbiter
  import keynsham_ram_arb_pkg::*;
#(
  parameter int TIMEOUT   = 16,
  parameter int TIMEOUT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_bytesel,
  input  logic [31:0] m0_wr_val,
  input  logic        m0_wr_en,
  output logic [31:0] m0_data,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_bytesel,
  input  logic [31:0] m1_wr_val,
  input  logic        m1_wr_en,
  output logic [31:0] m1_data,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        ram_access,
  output logic        ram_cs,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_bytesel,
  output logic [31:0] ram_wr_val,
  output logic        ram_wr_en,
  input  logic [31:0] ram_data,
  input  logic        ram_ack
);

  arb_state_e           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_grant_q, last_grant_d;
  logic [1:0]           mask_q, mask_d;      // owner req ignored for one cycle after its ack
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          addr_q, addr_d;
  logic [3:0]           bytesel_q, bytesel_d;
  logic [31:0]          wr_val_q, wr_val_d;
  logic                 wr_en_q, wr_en_d;

  logic [1:0]           req_eff;
  logic                 grant;
  logic                 done_ack, done_err;
  logic [31:0]          done_data;

  assign ram_cs      = ram_access;
  assign ram_addr    = addr_q;
  assign ram_bytesel = bytesel_q;
  assign ram_wr_val  = wr_val_q;

  // State and latched-payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= M_CPU;
      last_grant_q <= M_DBG;
      mask_q       <= 2'b00;
      cnt_q        <= '0;
      addr_q       <= '0;
      bytesel_q    <= '0;
      wr_val_q     <= '0;
      wr_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      bytesel_q    <= bytesel_d;
      wr_val_q     <= wr_val_d;
      wr_en_q      <= wr_en_d;
    end
  end

  // Next-state, round-robin pick, RAM strobes and completion status.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mask_d       = 2'b00;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    bytesel_d    = bytesel_q;
    wr_val_d     = wr_val_q;
    wr_en_d      = wr_en_q;
    ram_access   = 1'b0;
    ram_wr_en    = 1'b0;
    done_ack     = 1'b0;
    done_err     = 1'b0;
    done_data    = '0;
    req_eff      = {m1_req, m0_req} & ~mask_q;
    grant        = M_CPU;

    case (state_q)
      IDLE: begin
        if (|req_eff) begin
          // On a tie the master that did not win last time goes first.
          grant   = (&req_eff) ? ~last_grant_q : req_eff[1];
          owner_d = grant;
          if (grant == M_DBG) begin
            addr_d    = m1_addr;
            bytesel_d = m1_bytesel;
            wr_val_d  = m1_wr_val;
            wr_en_d   = m1_wr_en;
          end else begin
            addr_d    = m0_addr;
            bytesel_d = m0_bytesel;
            wr_val_d  = m0_wr_val;
            wr_en_d   = m0_wr_en;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ram_access = 1'b1;
        ram_wr_en  = wr_en_q;
        cnt_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (ram_ack) begin
          done_ack        = 1'b1;
          done_data       = ram_data;
          last_grant_d    = owner_q;
          mask_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end else if (cnt_q == TIMEOUT_W'(TIMEOUT - 1)) begin
          done_ack        = 1'b1;
          done_err        = 1'b1;
          done_data       = TIMEOUT_DATA;
          mask_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end else begin
          done_data = ram_data;
          cnt_d     = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Route completion status to the owning master; the other sees zeros.
  always_comb begin
    m0_ack  = done_ack & (owner_q == M_CPU);
    m0_err  = done_err & (owner_q == M_CPU);
    m0_data = (owner_q == M_CPU) ? done_data : 32'h0;
    m1_ack  = done_ack & (owner_q == M_DBG);
    m1_err  = done_err & (owner_q == M_DBG);
    m1_data = (owner_q == M_DBG) ? done_data : 32'h0;
  end

endmodule

// File: tb/tb_keynsham_ram_arbiter.sv
// Directed bench for keynsham_ram_arbiter: a table of single transactions
// followed by hand-written contention, timeout, reset and held-req sequences.
module tb_keynsham_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wr_en, m1_req, m1_wr_en;
  logic [31:0] m0_addr, m0_wr_val, m1_addr, m1_wr_val;
  logic [3:0]  m0_bytesel, m1_bytesel;
  logic [31:0] m0_data, m1_data;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        ram_access, ram_cs, ram_wr_en, ram_ack;
  logic [31:0] ram_addr, ram_wr_val, ram_data;
  logic [3:0]  ram_bytesel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keynsham_ram_arbiter #(.TIMEOUT(16), .TIMEOUT_W(5)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_bytesel(m0_bytesel),
    .m0_wr_val(m0_wr_val), .m0_wr_en(m0_wr_en),
    .m0_data(m0_data), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_bytesel(m1_bytesel),
    .m1_wr_val(m1_wr_val), .m1_wr_en(m1_wr_en),
    .m1_data(m1_data), .m1_ack(m1_ack), .m1_err(m1_err),
    .ram_access(ram_access), .ram_cs(ram_cs), .ram_addr(ram_addr),
    .ram_bytesel(ram_bytesel), .ram_wr_val(ram_wr_val), .ram_wr_en(ram_wr_en),
    .ram_data(ram_data), .ram_ack(ram_ack)
  );

  typedef struct {
    logic        m;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  bs;
    logic [31:0] wv;
    logic [31:0] rd;        // value the stub RAM returns
    logic [31:0] exp_data;  // value the owner must see with its ack
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic m, input logic req, input logic wr,
                       input logic [31:0] a, input logic [3:0] bs, input logic [31:0] wv);
    if (m == 1'b0) begin
      m0_req = req; m0_wr_en = wr; m0_addr = a; m0_bytesel = bs; m0_wr_val = wv;
    end else begin
      m1_req = req; m1_wr_en = wr; m1_addr = a; m1_bytesel = bs; m1_wr_val = wv;
    end
  endtask

  // One isolated access: req in N, issue in N+1, ack in N+2, req dropped in N+3.
  task automatic do_txn(input vec_t v, input string tag);
    logic [1:0] own;
    own = v.m ? 2'b10 : 2'b01;
    drive(v.m, 1'b1, v.wr, v.addr, v.bs, v.wv);
    tick();  // N+1 issue
    #1;
    chk({tag, " ram_access"}, {31'b0, ram_access}, 32'd1);
    chk({tag, " ram_cs"}, {31'b0, ram_cs}, 32'd1);
    chk({tag, " ram_addr"}, ram_addr, v.addr);
    chk({tag, " ram_bytesel"}, {28'b0, ram_bytesel}, {28'b0, v.bs});
    chk({tag, " ram_wr_val"}, ram_wr_val, v.wv);
    chk({tag, " ram_wr_en issue"}, {31'b0, ram_wr_en}, {31'b0, v.wr});
    chk({tag, " early ack"}, {30'b0, m1_ack, m0_ack}, 32'd0);
    tick();  // N+2 RAM acks
    ram_ack = 1'b1; ram_data = v.rd;
    #1;
    chk({tag, " ram_access after issue"}, {30'b0, ram_access, ram_wr_en}, 32'd0);
    chk({tag, " ack"}, {30'b0, m1_ack, m0_ack}, {30'b0, own});
    chk({tag, " err"}, {30'b0, m1_err, m0_err}, 32'd0);
    chk({tag, " owner data"}, v.m ? m1_data : m0_data, v.exp_data);
    chk({tag, " other data"}, v.m ? m0_data : m1_data, 32'd0);
    tick();  // N+3 master drops req
    ram_ack = 1'b0; ram_data = '0;
    drive(v.m, 1'b0, 1'b0, '0, '0, '0);
    #1;
    chk({tag, " idle after ack"}, {29'b0, ram_access, m1_ack, m0_ack}, 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_addr [4];
    logic [1:0]  exp_own  [4];
    int          w;
    int          early;

    vecs[0] = '{m: 1'b0, wr: 1'b0, addr: 32'h100,  bs: 4'hF, wv: 32'h0,        rd: 32'h12345678, exp_data: 32'h12345678};
    vecs[1] = '{m: 1'b1, wr: 1'b1, addr: 32'h40,   bs: 4'h3, wv: 32'hA5A5A5A5, rd: 32'h0,        exp_data: 32'h0};
    vecs[2] = '{m: 1'b0, wr: 1'b1, addr: 32'h2000, bs: 4'hC, wv: 32'h11223344, rd: 32'h0,        exp_data: 32'h0};
    vecs[3] = '{m: 1'b1, wr: 1'b0, addr: 32'hFFFC, bs: 4'hF, wv: 32'h0,        rd: 32'hCAFEBABE, exp_data: 32'hCAFEBABE};
    exp_addr = '{32'hA0, 32'hB0, 32'hA0, 32'hB0};
    exp_own  = '{2'b01, 2'b10, 2'b01, 2'b10};

    rst = 1'b1; ram_ack = 1'b0; ram_data = '0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) tick();
    #1;
    chk("reset ram strobes", {29'b0, ram_access, ram_cs, ram_wr_en}, 32'd0);
    chk("reset ram_addr", ram_addr, 32'd0);
    chk("reset ram_wr_val", ram_wr_val, 32'd0);
    chk("reset acks", {28'b0, m1_ack, m1_err, m0_ack, m0_err}, 32'd0);
    chk("reset data", m0_data | m1_data, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      do_txn(vecs[i], $sformatf("vec%0d", i));
      $display("vec%0d done: m%0d wr=%0b addr=%h", i, vecs[i].m, vecs[i].wr, vecs[i].addr);
    end

    // Contention from reset, both requests held throughout four accesses.
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'hA0, 4'hF, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'hB0, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      w = 0;
      do begin
        tick(); #1; w++;
      end while (!ram_access && w < 6);
      chk($sformatf("contention issue%0d seen", i), {31'b0, ram_access}, 32'd1);
      chk($sformatf("contention grant%0d addr", i), ram_addr, exp_addr[i]);
      tick();
      ram_ack = 1'b1; ram_data = 32'h1000 + i;
      #1;
      chk($sformatf("contention ack%0d", i), {30'b0, m1_ack, m0_ack}, {30'b0, exp_own[i]});
      tick();
      ram_ack = 1'b0; ram_data = '0;
      $display("contention access %0d: addr=%h", i, exp_addr[i]);
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    tick(); #1;
    chk("contention quiet", {31'b0, ram_access}, 32'd0);
    tick();

    // Timeout: RAM never acks.
    drive(1'b0, 1'b1, 1'b0, 32'h500, 4'hF, 32'h0);
    tick(); #1;
    chk("timeout issue", {31'b0, ram_access}, 32'd1);
    early = 0;
    for (int k = 1; k < 16; k++) begin
      tick(); #1;
      if (m0_ack || m0_err || m1_ack) early++;
    end
    chk("timeout early ack count", early, 32'd0);
    tick(); #1;
    chk("timeout ack/err", {30'b0, m0_ack, m0_err}, 32'd3);
    chk("timeout data", m0_data, 32'hDEADDEAD);
    chk("timeout m1 quiet", {30'b0, m1_ack, m1_err}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    ram_ack = 1'b1; ram_data = 32'h77777777;  // stray ack
    #1;
    chk("stray ack ignored", {29'b0, ram_access, m1_ack, m0_ack}, 32'd0);
    tick();
    ram_ack = 1'b0; ram_data = '0;
    $display("timeout sequence done");
    do_txn('{m: 1'b1, wr: 1'b0, addr: 32'h600, bs: 4'h1, wv: 32'h0, rd: 32'h0BADF00D, exp_data: 32'h0BADF00D}, "post-timeout");

    // Reset during WAIT.
    drive(1'b0, 1'b1, 1'b1, 32'h700, 4'h5, 32'h99887766);
    tick(); #1;
    chk("rstwait issue", {31'b0, ram_access}, 32'd1);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("rstwait no ack in wait", {30'b0, m1_ack, m0_ack}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstwait ram strobes", {29'b0, ram_access, ram_cs, ram_wr_en}, 32'd0);
    chk("rstwait ram_addr", ram_addr, 32'd0);
    chk("rstwait ram_bytesel", {28'b0, ram_bytesel}, 32'd0);
    chk("rstwait ram_wr_val", ram_wr_val, 32'd0);
    chk("rstwait acks", {30'b0, m1_ack, m0_ack}, 32'd0);
    $display("reset during wait done");
    do_txn('{m: 1'b1, wr: 1'b1, addr: 32'h800, bs: 4'hF, wv: 32'h13579BDF, rd: 32'h0, exp_data: 32'h0}, "post-reset");

    // Held req: m0 keeps req one cycle past its ack.
    drive(1'b0, 1'b1, 1'b0, 32'h300, 4'hF, 32'h0);
    tick(); #1;
    chk("held issue", {31'b0, ram_access}, 32'd1);
    tick();
    ram_ack = 1'b1; ram_data = 32'h55AA55AA;
    #1;
    chk("held ack", {30'b0, m1_ack, m0_ack}, 32'd1);
    chk("held data", m0_data, 32'h55AA55AA);
    tick();
    ram_ack = 1'b0; ram_data = '0;
    #1;
    chk("held masked cycle", {30'b0, ram_access, m0_ack}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h300, 4'hF, 32'h0);
    #1;
    chk("held no reissue", {31'b0, ram_access}, 32'd0);
    tick(); #1;
    chk("held still idle", {31'b0, ram_access}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h304, 4'hF, 32'h0);
    tick(); #1;
    chk("held new issue", {31'b0, ram_access}, 32'd1);
    chk("held new addr", ram_addr, 32'h304);
    tick();
    ram_ack = 1'b1; ram_data = 32'h2468ACE0;
    #1;
    chk("held new ack", {30'b0, m1_ack, m0_ack}, 32'd1);
    tick();
    ram_ack = 1'b0; ram_data = '0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    $display("held req sequence done");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
